// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (IF) and data access (D).
// Data access wins arbitration unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic [31:0] ifData,
    output logic        ifValid,
    input  logic        dReq,
    input  logic        dWrite,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic [31:0] dRdata,
    output logic        dValid,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut,
    output logic        busy
);

    localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                owner_if;
    logic                grant_if;
    logic                grant_d;

    // Fetch is forced through once it has lost STARVE_LIMIT consecutive contested grants.
    always_comb begin
        grant_d  = dReq && !(ifReq && (starve_cnt == STARVE_W'(STARVE_LIMIT)));
        grant_if = ifReq && !grant_d;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_if   <= 1'b0;
            ifData     <= '0;
            ifValid    <= 1'b0;
            dRdata     <= '0;
            dValid     <= 1'b0;
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            memAddr    <= '0;
            memDataIn  <= '0;
            busy       <= 1'b0;
        end else begin
            ifValid <= 1'b0;
            dValid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        state    <= ACCESS;
                        owner_if <= grant_if;
                        busy     <= 1'b1;
                        lat_cnt  <= LAT_W'(MEM_LATENCY - 1);
                        memAddr  <= grant_if ? ifAddr : dAddr;
                        memRead  <= !(grant_d && dWrite);
                        memWrite <= grant_d && dWrite;
                        if (grant_d) begin
                            memDataIn <= dWdata;
                        end
                        if (grant_d && ifReq) begin
                            if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                                starve_cnt <= starve_cnt + STARVE_W'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // The edge closing the last driven cycle is where read data is valid.
                    if (lat_cnt == '0) begin
                        state    <= RESP;
                        memRead  <= 1'b0;
                        memWrite <= 1'b0;
                        if (owner_if) begin
                            ifValid <= 1'b1;
                            ifData  <= memDataOut;
                        end else begin
                            dValid <= 1'b1;
                            if (!memWrite) begin
                                dRdata <= memDataOut;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus concurrent random IF/D traffic,
// with a bus-side memory model and a rule-level arbitration model in a free-running monitor.
module tb_mem_port_arbiter;

    localparam int ML = 2;
    localparam int SL = 3;

    logic        CLK;
    logic        RES;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifData;
    logic        ifValid;
    logic        dReq;
    logic        dWrite;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        dValid;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    bit mon_en = 0;

    logic [31:0] if_exp[$];
    logic [31:0] d_exp_data[$];
    bit          d_exp_store[$];
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] d_shadow[logic [31:0]];

    mem_port_arbiter #(.MEM_LATENCY(ML), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .RES(RES),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifValid(ifValid),
        .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dValid(dValid),
        .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
        .memDataIn(memDataIn), .memDataOut(memDataOut), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle++;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=event_missing_or_unexpected required=protocol_ok", name);
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus_if(input logic [31:0] addr);
        ifReq  = 1'b1;
        ifAddr = addr;
        if_exp.push_back(init_word(addr));
    endtask

    task automatic apply_stimulus_d(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        dReq   = 1'b1;
        dWrite = wr;
        dAddr  = addr;
        dWdata = data;
        d_exp_store.push_back(wr);
        if (wr) begin
            d_shadow[addr] = data;
            d_exp_data.push_back(32'h0);
        end else begin
            d_exp_data.push_back(d_shadow.exists(addr) ? d_shadow[addr] : init_word(addr));
        end
    endtask

    // Memory: read data is only correct in the final cycle of a read window, garbage otherwise.
    int rd_run = 0;
    int wr_run = 0;
    always @(posedge CLK) begin
        #1;
        rd_run = (memRead === 1'b1) ? rd_run + 1 : 0;
        wr_run = (memWrite === 1'b1) ? wr_run + 1 : 0;
        if (memRead === 1'b1 && rd_run == ML)
            memDataOut = mem_arr.exists(memAddr) ? mem_arr[memAddr] : init_word(memAddr);
        else
            memDataOut = $urandom;
        if (memWrite === 1'b1 && wr_run == ML)
            mem_arr[memAddr] = memDataIn;
    end

    bit          prev_if, prev_d, prev_dwrite, prev_strobe, prev_res;
    logic [31:0] prev_ifaddr, prev_daddr, prev_dwdata;
    int          starve_m = 0;
    int          win_cnt = 0;
    bit          win_if, win_wr;
    logic [31:0] win_addr, win_data;
    logic [31:0] last_d = 32'h0;

    always @(negedge CLK) begin
        bit          strobe, exp_if, exp_wr, st;
        logic [31:0] e;
        strobe = (memRead === 1'b1) || (memWrite === 1'b1);
        if (mon_en) begin
            if (prev_res) begin
                check_output("post_reset_outputs", {28'b0, busy, memRead, memWrite, ifValid | dValid}, 32'h0);
                win_cnt = 0;
            end else begin
                if (strobe && !prev_strobe) begin
                    if (!(prev_if || prev_d)) report_fail("spurious_grant");
                    exp_if = prev_if && (!prev_d || starve_m == SL);
                    exp_wr = !exp_if && prev_dwrite;
                    check_output("grant_addr", memAddr, exp_if ? prev_ifaddr : prev_daddr);
                    check_output("grant_dir", {30'b0, memRead, memWrite}, {30'b0, !exp_wr, exp_wr});
                    if (exp_wr) check_output("grant_wdata", memDataIn, prev_dwdata);
                    if (!exp_if && prev_if) starve_m = (starve_m < SL) ? starve_m + 1 : SL;
                    else starve_m = 0;
                    win_if = exp_if; win_wr = exp_wr; win_addr = memAddr; win_data = memDataIn;
                    win_cnt = 1;
                end else if (strobe) begin
                    check_output("window_addr_stable", memAddr, win_addr);
                    check_output("window_dir_stable", {30'b0, memRead, memWrite}, {30'b0, !win_wr, win_wr});
                    if (win_wr) check_output("window_wdata_stable", memDataIn, win_data);
                    win_cnt++;
                end else if (prev_strobe) begin
                    check_output("window_length", win_cnt, ML);
                    check_output("resp_owner", {30'b0, ifValid, dValid}, {30'b0, win_if, !win_if});
                end
                check_output("busy", {31'b0, busy}, {31'b0, strobe || prev_strobe});
            end
            if (ifValid) begin
                if (if_exp.size() == 0) report_fail("if_spurious_valid");
                else begin
                    e = if_exp.pop_front();
                    check_output("if_data", ifData, e);
                end
            end
            if (dValid) begin
                if (d_exp_data.size() == 0) report_fail("d_spurious_valid");
                else begin
                    e  = d_exp_data.pop_front();
                    st = d_exp_store.pop_front();
                    if (st) check_output("d_store_rdata_hold", dRdata, last_d);
                    else begin
                        check_output("d_load_data", dRdata, e);
                        last_d = e;
                    end
                end
            end
            if (RES) begin
                starve_m = 0;
                last_d   = 32'h0;
            end
        end
        prev_if     = ifReq;
        prev_d      = dReq;
        prev_dwrite = dWrite;
        prev_ifaddr = ifAddr;
        prev_daddr  = dAddr;
        prev_dwdata = dWdata;
        prev_strobe = strobe;
        prev_res    = RES;
    end

    // Called at the start of the grant cycle; returns after sampling the response cycle.
    task automatic check_access(input string tag, input logic [31:0] addr, input bit wr,
                                input logic [31:0] wdata, input bit own_if);
        @(negedge CLK);
        check_output({tag, "_grant_cycle_idle"}, {30'b0, memRead, memWrite}, 32'h0);
        for (int k = 1; k <= ML; k++) begin
            next_cycle();
            @(negedge CLK);
            check_output({tag, "_addr"}, memAddr, addr);
            check_output({tag, "_dir"}, {30'b0, memRead, memWrite}, {30'b0, !wr, wr});
            if (wr) check_output({tag, "_wdata"}, memDataIn, wdata);
            check_output({tag, "_busy"}, {31'b0, busy}, 32'h1);
        end
        next_cycle();
        @(negedge CLK);
        check_output({tag, "_valid"}, {30'b0, ifValid, dValid}, {30'b0, own_if, !own_if});
        check_output({tag, "_resp_strobes"}, {30'b0, memRead, memWrite}, 32'h0);
    endtask

    task automatic wait_valid(output bit got_if, output bit ok);
        ok = 0;
        got_if = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (ifValid || dValid) begin
                got_if = ifValid;
                ok = 1;
                break;
            end
        end
    endtask

    task automatic starvation_test;
        int start, elapsed;
        bit got_if, ok, first_if_seen;
        start = cycle;
        first_if_seen = 0;
        apply_stimulus_if(32'h300);
        apply_stimulus_d(1'b0, 32'h1000, 32'h0);
        for (int n = 0; n < 9; n++) begin
            wait_valid(got_if, ok);
            if (!ok) begin
                report_fail("starve_timeout");
                break;
            end
            check_output("starve_order", {31'b0, got_if}, {31'b0, (n % (SL + 1)) == SL});
            if (got_if && !first_if_seen) begin
                first_if_seen = 1;
                elapsed = cycle - start;
                check_output("starve_if_within_16", {31'b0, elapsed <= 16}, 32'h1);
            end
            next_cycle();
            if (got_if) begin
                if (n < 7) apply_stimulus_if(32'h300 + 32'(4 * (n + 1)));
                else ifReq = 1'b0;
            end else begin
                if (n < 7) apply_stimulus_d(1'b0, 32'h1000 + 32'(4 * (n + 1)), 32'h0);
                else dReq = 1'b0;
            end
        end
        ifReq = 1'b0;
        dReq  = 1'b0;
    endtask

    task automatic if_driver(input int n);
        bit seen;
        for (int i = 0; i < n; i++) begin
            seen = 0;
            repeat ($urandom_range(0, 3)) next_cycle();
            apply_stimulus_if(32'h400 + 32'(4 * $urandom_range(0, 767)));
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge CLK);
                seen = ifValid;
            end
            next_cycle();
            ifReq = 1'b0;
            if (!seen) begin
                report_fail("if_timeout");
                break;
            end
        end
    endtask

    task automatic d_driver(input int n);
        bit seen;
        for (int i = 0; i < n; i++) begin
            seen = 0;
            repeat ($urandom_range(0, 3)) next_cycle();
            apply_stimulus_d(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * $urandom_range(0, 15)), $urandom);
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge CLK);
                seen = dValid;
            end
            next_cycle();
            dReq = 1'b0;
            if (!seen) begin
                report_fail("d_timeout");
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: actual=still_running required=finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        RES = 1'b1; ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWrite = 1'b0;
        dAddr = '0; dWdata = '0; memDataOut = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_output("reset_strobes", {30'b0, memRead, memWrite}, 32'h0);
        check_output("reset_valids", {30'b0, ifValid, dValid}, 32'h0);
        check_output("reset_busy", {31'b0, busy}, 32'h0);
        check_output("reset_ifData", ifData, 32'h0);
        check_output("reset_dRdata", dRdata, 32'h0);
        check_output("reset_memAddr", memAddr, 32'h0);
        next_cycle();
        RES = 1'b0;
        mon_en = 1;
        next_cycle();

        $display("[TB] IF read then back-to-back IF");
        apply_stimulus_if(32'h40);
        check_access("if_read", 32'h40, 1'b0, 32'h0, 1'b1);
        check_output("if_read_data", ifData, 32'h0050_0093);
        next_cycle();
        apply_stimulus_if(32'h48);
        check_access("if_b2b", 32'h48, 1'b0, 32'h0, 1'b1);
        next_cycle();
        ifReq = 1'b0;
        next_cycle();

        $display("[TB] simultaneous IF and D load");
        apply_stimulus_if(32'h44);
        apply_stimulus_d(1'b0, 32'h200, 32'h0);
        check_access("sim_d", 32'h200, 1'b0, 32'h0, 1'b0);
        next_cycle();
        dReq = 1'b0;
        check_access("sim_if", 32'h44, 1'b0, 32'h0, 1'b1);
        next_cycle();
        ifReq = 1'b0;
        next_cycle();

        $display("[TB] store and read-back");
        apply_stimulus_d(1'b1, 32'h100, 32'hDEAD_BEEF);
        check_access("store", 32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check_output("store_rdata_unchanged", dRdata, init_word(32'h200));
        next_cycle();
        dReq = 1'b0;
        dWrite = 1'b0;
        next_cycle();
        apply_stimulus_d(1'b0, 32'h100, 32'h0);
        check_access("readback", 32'h100, 1'b0, 32'h0, 1'b0);
        next_cycle();
        dReq = 1'b0;
        next_cycle();

        $display("[TB] starvation");
        starvation_test();
        next_cycle();

        $display("[TB] reset mid-access");
        ifReq = 1'b1;
        ifAddr = 32'h80;
        next_cycle();
        RES = 1'b1;
        @(negedge CLK);
        check_output("rst_mid_strobe", {31'b0, memRead}, 32'h1);
        next_cycle();
        RES = 1'b0;
        ifReq = 1'b0;
        @(negedge CLK);
        check_output("rst_after_strobe", {31'b0, memRead}, 32'h0);
        check_output("rst_after_busy", {31'b0, busy}, 32'h0);
        check_output("rst_no_valid", {31'b0, ifValid}, 32'h0);
        next_cycle();
        apply_stimulus_if(32'h80);
        check_access("rst_retry", 32'h80, 1'b0, 32'h0, 1'b1);
        next_cycle();
        ifReq = 1'b0;
        next_cycle();

        $display("[TB] random concurrent traffic");
        fork
            if_driver(30);
            d_driver(30);
        join
        repeat (5) next_cycle();
        check_output("if_queue_drained", if_exp.size(), 32'h0);
        check_output("d_queue_drained", d_exp_data.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single external memory port (memRead/memWrite/memAddr/memDataIn/memDataOut) between two requesters: instruction fetch (IF) and load/store data access (D).
- Sits between the fetch/mem-access stages of the CPU core and the memory.
- Sequences each access over a fixed memory latency and returns data with a one-cycle valid pulse.
- Data access has priority; a starvation counter guarantees fetch progress.

Parameters:
MEM_LATENCY, 2, cycles the memory port is driven per access (>=1); memDataOut is valid in the last of these cycles.
STARVE_LIMIT, 3, consecutive D grants allowed while ifReq is pending before IF is forced to win (>=1).

Ports:
CLK  in  1  clock, rising edge.
RES  in  1  synchronous, active-high reset.
ifReq  in  1  fetch request; held high with ifAddr stable until ifValid.
ifAddr  in  32  fetch address.
ifData  out  32  fetched word, valid when ifValid.
ifValid  out  1  one-cycle completion pulse for IF.
dReq  in  1  data request; held high with dWrite/dAddr/dWdata stable until dValid.
dWrite  in  1  1=store, 0=load.
dAddr  in  32  data address.
dWdata  in  32  store data.
dRdata  out  32  load data, valid when dValid.
dValid  out  1  one-cycle completion pulse for D (loads and stores).
memRead  out  1  memory read strobe.
memWrite  out  1  memory write strobe.
memAddr  out  32  memory address.
memDataIn  out  32  memory write data.
memDataOut  in  32  memory read data.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset:
  - Single clock CLK. Reset RES is synchronous and active-high.
  - All outputs are registered. On reset all outputs go to 0, state goes to IDLE, and the latency and starve counters clear.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration in cycle t when either request is high:
  - dReq only -> grant D. ifReq only -> grant IF.
  - Both high -> grant D, unless starveCnt == STARVE_LIMIT, then grant IF.
  - At the end of cycle t: latch owner, address, write flag and write data; load latCnt = MEM_LATENCY-1; go to ACCESS.
  - No request -> stay in IDLE; all strobes 0.
- ACCESS, cycles t+1 .. t+MEM_LATENCY:
  - memAddr and memDataIn are driven from the latched registers, stable for the whole window.
  - memRead = !write and memWrite = write, asserted for every cycle of the window.
  - latCnt decrements each cycle. When latCnt == 0, the rising edge ending cycle t+MEM_LATENCY samples memDataOut (reads only), clears the strobes, and moves to RESP.
- RESP, cycle t+MEM_LATENCY+1:
  - Owner's valid = 1 for exactly this cycle.
  - IF read -> ifData = sampled word. D load -> dRdata = sampled word. D store -> dRdata holds its previous value.
  - ifData/dRdata hold their values until the next completion of the same requester.
  - Requests are ignored in RESP, because the owner's req is still high this cycle. Next state is IDLE.
  - Earliest next grant is cycle t+MEM_LATENCY+2. Throughput is one access per MEM_LATENCY+2 cycles.
- Starve counter, updated at grant:
  - D granted while ifReq high -> starveCnt+1, saturating at STARVE_LIMIT.
  - IF granted, or D granted with ifReq low -> starveCnt = 0.
- Never more than one outstanding transaction. Inputs are not sampled outside IDLE, except memDataOut on the last ACCESS edge.
- Reset mid-transaction: the transaction is abandoned.
  - Strobes are 0 from the cycle after the reset edge.
  - No valid pulse is issued for the abandoned access.
  - The requester re-presents the request; it is served normally after reset deasserts.
- A request dropped before its valid pulse is a protocol violation with undefined result; no recovery logic is required.
- Address/data pass through unmodified; alignment is the requester's responsibility.

Test Plan:
- IF-only read, MEM_LATENCY=2: ifReq=1, ifAddr=0x40 in cycle 0; memory returns 0x00500093 in cycle 2.
  -> memRead=1, memAddr=0x40 in cycles 1-2; ifValid=1 only in cycle 3 with ifData=0x00500093; busy=1 in cycles 1-3.
- Simultaneous requests: ifReq (0x44) and dReq load (0x200) both in cycle 0.
  -> D served first: memAddr=0x200 in cycles 1-2, dValid in cycle 3.
  -> IF granted in cycle 4: memAddr=0x44 in cycles 5-6, ifValid in cycle 7.
- Store: dReq=1, dWrite=1, dAddr=0x100, dWdata=0xDEADBEEF in cycle 0.
  -> memWrite=1, memRead=0, memAddr=0x100, memDataIn=0xDEADBEEF in cycles 1-2; dValid in cycle 3; dRdata unchanged.
- Starvation, STARVE_LIMIT=3: dReq re-asserted immediately after every dValid, ifReq held continuously.
  -> grant sequence D,D,D,IF,D,D,D,IF; ifValid occurs within 4 transactions (16 cycles).
- Reset mid-access: IF read granted in cycle 0; RES=1 in cycle 1.
  -> memRead=0 and busy=0 from cycle 2; no ifValid.
  -> With ifReq re-presented after RES drops in cycle 2, grant in cycle 3, ifValid in cycle 6.
- Back-to-back IF: a second ifReq (0x48) asserted in cycle 4 after the first completes.
  -> grant in cycle 4, memAddr=0x48 in cycles 5-6, ifValid in cycle 7.
  -> No grant is issued in the RESP cycle 3 even though ifReq is high.
